light_phase_monitor: RTL and testbench



---
 rtl/light_phase_monitor.sv | 137 +++++++++++++
 tb/tb_light_phase_monitor.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/light_phase_monitor.sv
// light_phase_monitor: passive checker for the s298 traffic-light lamp buses.
// Decodes per-direction phases, tracks dwell and cycles, flags illegal behaviour.
module light_phase_monitor #(
    parameter int CNT_W      = 8,
    parameter int MIN_GREEN  = 4,
    parameter int MIN_YELLOW = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [1:0]       R,
    input  logic [1:0]       Y,
    input  logic [1:0]       G,
    input  logic             clear,
    output logic [1:0]       lamp0,
    output logic [1:0]       lamp1,
    output logic [CNT_W-1:0] dwell0,
    output logic [CNT_W-1:0] dwell1,
    output logic [CNT_W-1:0] cycles,
    output logic [4:0]       err,
    output logic             err_pulse
);

    typedef enum logic [1:0] {
        PH_UNK = 2'd0,
        PH_RED = 2'd1,
        PH_YEL = 2'd2,
        PH_GRN = 2'd3
    } phase_e;

    localparam logic [CNT_W-1:0] DW_MAX = '1;
    localparam logic [CNT_W-1:0] MIN_G  = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MIN_Y  = CNT_W'(MIN_YELLOW);

    phase_e           samp [2];
    phase_e           lamp_q [2];
    phase_e           lamp_d [2];
    logic [CNT_W-1:0] dwell_q [2];
    logic [CNT_W-1:0] dwell_d [2];
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [4:0]       err_q, err_d;
    logic             err_pulse_q, err_pulse_d;
    logic [4:0]       new_err;
    logic             cyc_inc;
    logic             step_ok;

    // Decode each direction's one-hot lamp triple into a phase
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            case ({R[d], Y[d], G[d]})
                3'b100:  samp[d] = PH_RED;
                3'b010:  samp[d] = PH_YEL;
                3'b001:  samp[d] = PH_GRN;
                default: samp[d] = PH_UNK;
            endcase
        end
    end

    // Next phase/dwell per direction, error detection and cycle counting
    always_comb begin
        new_err = '0;
        cyc_inc = 1'b0;
        step_ok = 1'b0;
        for (int d = 0; d < 2; d++) begin
            lamp_d[d]  = lamp_q[d];
            dwell_d[d] = dwell_q[d];
            if (samp[d] == PH_UNK) begin
                lamp_d[d]  = PH_UNK;
                dwell_d[d] = '0;
                new_err[0] = 1'b1;
            end else if (lamp_q[d] == PH_UNK) begin
                lamp_d[d]  = samp[d];
                dwell_d[d] = CNT_W'(1);
            end else if (samp[d] == lamp_q[d]) begin
                if (dwell_q[d] != DW_MAX)
                    dwell_d[d] = dwell_q[d] + CNT_W'(1);
            end else begin
                lamp_d[d]  = samp[d];
                dwell_d[d] = CNT_W'(1);
                step_ok = (lamp_q[d] == PH_GRN && samp[d] == PH_YEL) ||
                          (lamp_q[d] == PH_YEL && samp[d] == PH_RED) ||
                          (lamp_q[d] == PH_RED && samp[d] == PH_GRN);
                if (!step_ok)
                    new_err[2] = 1'b1;
                if (lamp_q[d] == PH_GRN && dwell_q[d] < MIN_G)
                    new_err[3] = 1'b1;
                if (lamp_q[d] == PH_YEL && dwell_q[d] < MIN_Y)
                    new_err[4] = 1'b1;
                if (d == 0 && lamp_q[d] == PH_RED && samp[d] == PH_GRN)
                    cyc_inc = 1'b1;
            end
        end
        if (samp[0] != PH_UNK && samp[1] != PH_UNK &&
            samp[0] != PH_RED && samp[1] != PH_RED)
            new_err[1] = 1'b1;
    end

    // Sticky flags and cycle count; clear wins over same-edge updates
    always_comb begin
        err_pulse_d = |new_err;
        err_d       = err_q | new_err;
        cycles_d    = cycles_q + CNT_W'(cyc_inc);
        if (clear) begin
            err_d    = '0;
            cycles_d = '0;
        end
    end

    // State register with asynchronous reset
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int d = 0; d < 2; d++) begin
                lamp_q[d]  <= PH_UNK;
                dwell_q[d] <= '0;
            end
            cycles_q    <= '0;
            err_q       <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                lamp_q[d]  <= lamp_d[d];
                dwell_q[d] <= dwell_d[d];
            end
            cycles_q    <= cycles_d;
            err_q       <= err_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign lamp0     = lamp_q[0];
    assign lamp1     = lamp_q[1];
    assign dwell0    = dwell_q[0];
    assign dwell1    = dwell_q[1];
    assign cycles    = cycles_q;
    assign err       = err_q;
    assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_light_phase_monitor.sv
// tb_light_phase_monitor: directed lamp sequences with hand-computed
// expectations queued by the driver and checked by an independent monitor.
module tb_light_phase_monitor;

    localparam logic [1:0] UNK = 2'd0;
    localparam logic [1:0] RED = 2'd1;
    localparam logic [1:0] YEL = 2'd2;
    localparam logic [1:0] GRN = 2'd3;

    typedef struct packed {
        logic [1:0] l0;
        logic [1:0] l1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] cy;
        logic [4:0] er;
        logic       pl;
    } exp_t;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [1:0] R = '0;
    logic [1:0] Y = '0;
    logic [1:0] G = '0;
    logic       clear = 1'b0;
    logic [1:0] lamp0, lamp1;
    logic [7:0] dwell0, dwell1, cycles;
    logic [4:0] err;
    logic       err_pulse;

    int checks   = 0;
    int failures = 0;
    exp_t q[$];

    light_phase_monitor #(.CNT_W(8), .MIN_GREEN(4), .MIN_YELLOW(2)) dut (
        .Clock(Clock), .Reset(Reset), .R(R), .Y(Y), .G(G), .clear(clear),
        .lamp0(lamp0), .lamp1(lamp1), .dwell0(dwell0), .dwell1(dwell1),
        .cycles(cycles), .err(err), .err_pulse(err_pulse)
    );

    always #5 Clock = ~Clock;

    task automatic cmp(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic chk(input exp_t e);
        cmp("lamp0", int'(lamp0), int'(e.l0));
        cmp("lamp1", int'(lamp1), int'(e.l1));
        cmp("dwell0", int'(dwell0), int'(e.d0));
        cmp("dwell1", int'(dwell1), int'(e.d1));
        cmp("cycles", int'(cycles), int'(e.cy));
        cmp("err", int'(err), int'(e.er));
        cmp("err_pulse", int'(err_pulse), int'(e.pl));
    endtask

    // Monitor: every edge, compare outputs against the oldest expectation
    always @(posedge Clock) begin
        #1;
        if (q.size() != 0) chk(q.pop_front());
    end

    task automatic cyc(input logic [1:0] r, input logic [1:0] y,
                       input logic [1:0] g, input logic clr,
                       input logic [1:0] l0, input logic [1:0] l1,
                       input int d0, input int d1, input int cy,
                       input logic [4:0] er, input logic pl);
        exp_t e;
        @(negedge Clock);
        R = r; Y = y; G = g; clear = clr;
        e.l0 = l0; e.l1 = l1;
        e.d0 = 8'(d0); e.d1 = 8'(d1); e.cy = 8'(cy);
        e.er = er; e.pl = pl;
        q.push_back(e);
    endtask

    task automatic ph(input logic [1:0] p0, input logic [1:0] p1,
                      input logic clr,
                      input logic [1:0] l0, input logic [1:0] l1,
                      input int d0, input int d1, input int cy,
                      input logic [4:0] er, input logic pl);
        logic [1:0] r, y, g;
        r = {p1 == RED, p0 == RED};
        y = {p1 == YEL, p0 == YEL};
        g = {p1 == GRN, p0 == GRN};
        cyc(r, y, g, clr, l0, l1, d0, d1, cy, er, pl);
    endtask

    initial begin
        exp_t z;
        z = '0;
        // reset held: outputs stay zero despite legal lamps
        ph(RED, GRN, 0, UNK, UNK, 0, 0, 0, 5'd0, 0);
        ph(RED, GRN, 0, UNK, UNK, 0, 0, 0, 5'd0, 0);
        @(posedge Clock);
        #2 Reset = 1'b0;

        // clean sequence
        for (int k = 1; k <= 5; k++)
            ph(RED, GRN, 0, RED, GRN, k, k, 0, 5'd0, 0);
        for (int k = 1; k <= 2; k++)
            ph(RED, YEL, 0, RED, YEL, 5 + k, k, 0, 5'd0, 0);
        ph(RED, RED, 0, RED, RED, 8, 1, 0, 5'd0, 0);
        for (int k = 1; k <= 5; k++)
            ph(GRN, RED, 0, GRN, RED, k, 1 + k, 1, 5'd0, 0);
        for (int k = 1; k <= 2; k++)
            ph(YEL, RED, 0, YEL, RED, k, 6 + k, 1, 5'd0, 0);
        ph(RED, RED, 0, RED, RED, 1, 9, 1, 5'd0, 0);
        ph(GRN, RED, 0, GRN, RED, 1, 10, 2, 5'd0, 0);

        // short green: 3 clocks then yellow
        for (int k = 2; k <= 3; k++)
            ph(GRN, RED, 0, GRN, RED, k, 9 + k, 2, 5'd0, 0);
        ph(YEL, RED, 0, YEL, RED, 1, 13, 2, 5'b01000, 1);
        ph(YEL, RED, 0, YEL, RED, 2, 14, 2, 5'b01000, 0);
        ph(RED, RED, 1, RED, RED, 1, 15, 0, 5'd0, 0);

        // conflict (both green), then illegal code on direction 0
        ph(GRN, GRN, 0, GRN, GRN, 1, 1, 1, 5'b00010, 1);
        cyc(2'b11, 2'b00, 2'b01, 0, UNK, RED, 0, 1, 1, 5'b01111, 1);
        ph(RED, RED, 1, RED, RED, 1, 2, 0, 5'd0, 0);

        // bad order RED->YELLOW; then detections lost under clear
        ph(YEL, RED, 0, YEL, RED, 1, 3, 0, 5'b00100, 1);
        ph(GRN, RED, 1, GRN, RED, 1, 4, 0, 5'd0, 1);
        ph(RED, RED, 1, RED, RED, 1, 5, 0, 5'd0, 1);

        // dwell saturation
        for (int i = 1; i <= 300; i++)
            ph(RED, RED, 0, RED, RED, (1 + i > 255) ? 255 : 1 + i,
               (5 + i > 255) ? 255 : 5 + i, 0, 5'd0, 0);

        // 256 minimum-length clean cycles: cycles wraps to 0
        for (int n = 1; n <= 256; n++) begin
            ph(GRN, RED, 0, GRN, RED, 1, 255, n % 256, 5'd0, 0);
            for (int k = 2; k <= 4; k++)
                ph(GRN, RED, 0, GRN, RED, k, 255, n % 256, 5'd0, 0);
            for (int k = 1; k <= 2; k++)
                ph(YEL, RED, 0, YEL, RED, k, 255, n % 256, 5'd0, 0);
            ph(RED, RED, 0, RED, RED, 1, 255, n % 256, 5'd0, 0);
        end

        // async reset while green with dwell0 = 7
        for (int k = 1; k <= 7; k++)
            ph(GRN, RED, 0, GRN, RED, k, 255, 1, 5'd0, 0);
        @(posedge Clock);
        #3 Reset = 1'b1;
        #1 chk(z);
        Reset = 1'b0;
        ph(GRN, RED, 0, GRN, RED, 1, 1, 0, 5'd0, 0);

        for (int t = 0; t < 10 && q.size() != 0; t++)
            @(posedge Clock);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
